next_pc_fetch_unit: RTL and testbench
=====================================

# next_pc_fetch_unit

Fetch-side partner of the ProgramCounter register. It consumes the current PC (`PCResult`) and issues an instruction-memory read with a ready handshake. It holds the fetched instruction for decode until decode accepts it. It also produces the next-PC value (`Address`) that the ProgramCounter loads on every clock edge, so it decides hold, advance-by-4, or branch/jump redirect.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000. Value driven on `Address` while `Reset` is high.
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-high; clears all state immediately.
- `PCResult` input 32: current PC from the ProgramCounter.
- `Address` output 32: next PC, combinational, fed to the ProgramCounter `Address` input.
- `MemReq` output 1: instruction read request.
- `MemAddr` output 32: word address for the request; stable while `MemReq` is high.
- `MemReady` input 1: memory has `MemData` valid; sampled only while `MemReq`=1.
- `MemData` input 32: instruction word.
- `Instruction` output 32: registered instruction to decode.
- `InstrPC` output 32: PC of `Instruction`.
- `InstrValid` output 1: `Instruction`/`InstrPC` valid.
- `Stall` input 1: decode cannot accept; holds the delivered instruction.
- `BranchTaken`, `BranchTarget[31:0]` input: redirect to the branch target.
- `Jump`, `JumpTarget[31:0]` input: redirect to the jump target; has priority over the branch.

## Operation
- **States.**
  - IDLE: no request.
  - ISSUE: `MemReq`=1, `MemAddr`=`PCResult`, `ReqAddr`<=`PCResult`.
  - WAIT: `MemReq`=1, `MemAddr`=`ReqAddr`.
  - DELIVER: `InstrValid`=1.
- **Transitions.**
  - IDLE -> ISSUE unconditionally.
  - ISSUE -> DELIVER if `MemReady`, else WAIT.
  - WAIT -> DELIVER on `MemReady`.
  - DELIVER -> ISSUE when `Stall`=0; stays in DELIVER when `Stall`=1.
- **Capture.** Entering DELIVER loads `Instruction`<=`MemData` and `InstrPC`<=`MemAddr`.
- **`Address` priority.**
  1. `Reset`: `RESET_VECTOR`.
  2. `Jump`: `{JumpTarget[31:2],2'b00}`.
  3. `BranchTaken`: `{BranchTarget[31:2],2'b00}`.
  4. DELIVER && !`Stall`: `PCResult`+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  5. Otherwise `PCResult` (hold).
- **Redirect (`Jump`|`BranchTaken`) in any non-IDLE state.**
  - Next state is ISSUE.
  - `InstrValid` is cleared next cycle.
- **Redirect in WAIT.**
  - The request is not withdrawn: `MemReq` stays high with `ReqAddr` until `MemReady`.
  - A squash flag is set, and the returned data is discarded; state then goes to ISSUE.
  - A redirect coincident with `MemReady` also discards that data.
- **Stall.** `Stall` never blocks a redirect. With `Stall`=1 in DELIVER, `Instruction`, `InstrPC` and `InstrValid` stay constant.
- **Memory side effects.** `MemReady` is ignored in IDLE and DELIVER.

## Timing
- **Reset values.** State IDLE, squash=0, `MemReq`=0, `MemAddr`=0, `InstrValid`=0, `Instruction`=0, `InstrPC`=0, `Address`=`RESET_VECTOR`.
- **Reset mid-operation.** An outstanding request is abandoned. The instruction memory shares `Reset`, so no stale `MemReady` follows.
- **Minimum fetch latency.** ISSUE with `MemReady`=1, then `InstrValid` on the next cycle; 2 cycles per instruction with zero-wait memory.
- **Wait states.** Each cycle of `MemReady`=0 adds one WAIT cycle.
- **PC timing.** `PCResult` advances on the edge ending an accepted DELIVER cycle, and equals the target on the edge following a redirect.
- **Combinational outputs.** `Address`, `MemReq` and `MemAddr` are combinational from state and inputs. `Instruction`, `InstrPC` and `InstrValid` are registered.

## Structure
- Package `fetch_pkg`:
  - state encoding (IDLE/ISSUE/WAIT/DELIVER);
  - `INSTR_BYTES`=4;
  - `WORD_ALIGN_MASK`=32'hFFFF_FFFC.
- Sub-module `next_pc_mux`: combinational `Address` priority selection, including the +4 adder and alignment. The FSM and capture registers live in `next_pc_fetch_unit`.

## Test plan
- **Reset and sequential fetch.** Hold `Reset` 2 cycles, then zero-wait memory returning 32'h2000_0000+addr.
  - `Address`=0 during reset.
  - `MemAddr` sequence 0, 4, 8.
  - `InstrValid` every second cycle with `InstrPC`=0, 4, 8.
- **Wait states.** `MemReady` low for 3 cycles on addr 4.
  - `MemReq` high 4 cycles with `MemAddr`=4 stable.
  - `Address`=4 held throughout.
  - `Instruction` captured once.
- **Stall.** `Stall`=1 for 5 cycles in DELIVER of addr 8.
  - `Instruction`/`InstrPC`=8 unchanged and `Address`=8.
  - `Address`=12 in the cycle `Stall` drops.
- **Redirect during WAIT.** `BranchTaken`=1, `BranchTarget`=32'h0000_0103 while waiting on addr 12.
  - `Address`=32'h100.
  - Data for 12 never appears on `InstrValid`.
  - Next `MemAddr`=32'h100.
- **Priority and wrap.**
  - Same-cycle `Jump`(32'h40) and branch(32'h80) -> `Address`=32'h40.
  - Start at 32'hFFFF_FFFC, accept -> `Address`=0.
- **Reset mid-WAIT.** Assert `Reset` asynchronously mid-cycle.
  - `MemReq`/`InstrValid` drop immediately.
  - `Address`=`RESET_VECTOR`.
  - Fetch restarts at 0 after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding and PC constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDeliver
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES     = 4;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/next_pc_fetch_unit_if.sv
// Instruction-memory read channel.
//   MemReq    : read request, held until MemReady
//   MemAddr   : word address, stable while MemReq is high
//   MemReady  : MemData valid, only meaningful while MemReq is high
//   MemData   : instruction word
// master = fetch unit, slave = instruction memory.
interface next_pc_fetch_unit_if;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemReady;
  logic [31:0] MemData;

  modport master (
    output MemReq,
    output MemAddr,
    input  MemReady,
    input  MemData
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    output MemReady,
    output MemData
  );
endinterface

// File: rtl/next_pc_mux.sv
// Next-PC selection for the ProgramCounter.
//   reset_i           : forces ResetVector
//   jump_i/_target_i  : jump redirect, highest priority after reset
//   branch_taken_i/.. : branch redirect
//   advance_i         : current instruction accepted, step by one word
//   pc_result_i       : current PC
//   address_o         : next PC (word aligned targets, +4 wraps modulo 2^32)
module next_pc_mux
  import fetch_pkg::*;
#(
  parameter logic [31:0] ResetVector = 32'h0000_0000
) (
  input  logic        reset_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        advance_i,
  input  logic [31:0] pc_result_i,
  output logic [31:0] address_o
);

  always_comb begin
    address_o = pc_result_i;
    if (reset_i) begin
      address_o = ResetVector;
    end else if (jump_i) begin
      address_o = jump_target_i & WORD_ALIGN_MASK;
    end else if (branch_taken_i) begin
      address_o = branch_target_i & WORD_ALIGN_MASK;
    end else if (advance_i) begin
      address_o = pc_result_i + 32'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/next_pc_fetch_unit.sv
// Fetch unit: issues instruction reads for PCResult, holds the fetched word for
// decode, and produces the next PC (Address) loaded by the ProgramCounter each edge.
//   Clk, Reset             : clock, asynchronous active-high reset
//   PCResult / Address     : current PC in, next PC out (combinational)
//   mem                    : instruction-memory read channel (master side)
//   Instruction/InstrPC/
//   InstrValid             : registered instruction handed to decode
//   Stall                  : decode holds the delivered instruction
//   BranchTaken/Target,
//   Jump/JumpTarget        : redirects, jump wins over branch
module next_pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [31:0]                 PCResult,
  output logic [31:0]                 Address,
  next_pc_fetch_unit_if.master        mem,
  output logic [31:0]                 Instruction,
  output logic [31:0]                 InstrPC,
  output logic                        InstrValid,
  input  logic                        Stall,
  input  logic                        BranchTaken,
  input  logic [31:0]                 BranchTarget,
  input  logic                        Jump,
  input  logic [31:0]                 JumpTarget
);

  fetch_state_e state_q, state_d;
  logic         squash_q, squash_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         redirect;

  assign redirect = Jump | BranchTaken;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= StIdle;
      squash_q      <= 1'b0;
      req_addr_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      squash_q      <= squash_d;
      req_addr_q    <= req_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    squash_d   = squash_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    unique case (state_q)
      StIdle: state_d = StIssue;
      StIssue: begin
        req_addr_d = PCResult;
        if (mem.MemReady) begin
          if (redirect) begin
            state_d = StIssue;
          end else begin
            state_d    = StDeliver;
            instr_d    = mem.MemData;
            instr_pc_d = mem_addr;
          end
        end else begin
          // An unanswered request cannot be withdrawn; a redirect here is
          // remembered and the returning data dropped once it arrives.
          state_d = StWait;
          if (redirect) squash_d = 1'b1;
        end
      end
      StWait: begin
        if (mem.MemReady) begin
          if (redirect || squash_q) begin
            state_d  = StIssue;
            squash_d = 1'b0;
          end else begin
            state_d    = StDeliver;
            instr_d    = mem.MemData;
            instr_pc_d = mem_addr;
          end
        end else if (redirect) begin
          squash_d = 1'b1;
        end
      end
      StDeliver: begin
        if (redirect || !Stall) state_d = StIssue;
      end
      default: state_d = StIdle;
    endcase
    instr_valid_d = (state_d == StDeliver);
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    unique case (state_q)
      StIssue: begin
        mem_req  = 1'b1;
        mem_addr = PCResult;
      end
      StWait: begin
        mem_req  = 1'b1;
        mem_addr = req_addr_q;
      end
      default: ;
    endcase
  end

  assign mem.MemReq  = mem_req;
  assign mem.MemAddr = mem_addr;
  assign Instruction = instr_q;
  assign InstrPC     = instr_pc_q;
  assign InstrValid  = instr_valid_q;

  next_pc_mux #(
    .ResetVector (RESET_VECTOR)
  ) u_next_pc_mux (
    .reset_i         (Reset),
    .jump_i          (Jump),
    .jump_target_i   (JumpTarget),
    .branch_taken_i  (BranchTaken),
    .branch_target_i (BranchTarget),
    .advance_i       ((state_q == StDeliver) && !Stall),
    .pc_result_i     (PCResult),
    .address_o       (Address)
  );

endmodule

// File: tb/tb_next_pc_fetch_unit.sv
// Bench for next_pc_fetch_unit. The bench owns the ProgramCounter (pc) and a
// transaction-level reference: a fetch is either pending for an address, or an
// instruction is held for decode; redirects while a fetch is pending mark it squashed.
module tb_next_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] address;
  logic [31:0] instruction, instr_pc;
  logic        instr_valid;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;

  next_pc_fetch_unit_if mem_if ();

  next_pc_fetch_unit #(
    .RESET_VECTOR (RV)
  ) dut (
    .Clk          (clk),
    .Reset        (rst),
    .PCResult     (pc),
    .Address      (address),
    .mem          (mem_if),
    .Instruction  (instruction),
    .InstrPC      (instr_pc),
    .InstrValid   (instr_valid),
    .Stall        (stall),
    .BranchTaken  (branch_taken),
    .BranchTarget (branch_target),
    .Jump         (jump),
    .JumpTarget   (jump_target)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_started, m_pending, m_squash, m_held;
  logic [31:0] m_req_addr, m_instr, m_instr_pc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next_pc();
    if (rst) return RV;
    if (jump) return {jump_target[31:2], 2'b00};
    if (branch_taken) return {branch_target[31:2], 2'b00};
    if (m_held && !stall) return pc + 32'd4;
    return pc;
  endfunction

  task automatic model_reset();
    m_started  = 0;
    m_pending  = 0;
    m_squash   = 0;
    m_held     = 0;
    m_req_addr = '0;
    m_instr    = '0;
    m_instr_pc = '0;
    pc         = RV;
  endtask

  // One clock cycle: drive inputs, check at negedge, advance model after the edge.
  task automatic cycle(input bit r, input bit st, input bit br, input bit j, input bit rdy,
                       input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] data);
    logic [31:0] e;
    bit          redirect;
    rst                   = r;
    stall                 = st;
    branch_taken          = br;
    jump                  = j;
    branch_target         = bt;
    jump_target           = jt;
    mem_if.MemReady = rdy;
    mem_if.MemData  = data;
    if (r) model_reset();
    @(negedge clk);
    e = model_next_pc();
    check_eq("address", address, e);
    check_eq("mem_req", {31'b0, mem_if.MemReq}, {31'b0, m_pending});
    check_eq("mem_addr", mem_if.MemAddr, m_pending ? m_req_addr : 32'h0);
    check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_held});
    check_eq("instruction", instruction, m_instr);
    check_eq("instr_pc", instr_pc, m_instr_pc);
    @(posedge clk);
    #1;
    redirect = br | j;
    if (!r) begin
      if (!m_started) begin
        m_started  = 1;
        m_pending  = 1;
        m_req_addr = e;
      end else if (m_held) begin
        if (redirect || !st) begin
          m_held     = 0;
          m_pending  = 1;
          m_req_addr = e;
        end
      end else if (m_pending) begin
        if (rdy) begin
          if (m_squash || redirect) begin
            m_squash   = 0;
            m_req_addr = e;
          end else begin
            m_held     = 1;
            m_pending  = 0;
            m_instr    = data;
            m_instr_pc = m_req_addr;
          end
        end else if (redirect) begin
          m_squash = 1;
        end
      end
      pc = e;
    end
  endtask

  // Directed cycle with memory data 0x2000_0000 + requested address
  task automatic dcyc(input bit r, input bit st, input bit br, input bit j, input bit rdy,
                      input logic [31:0] bt, input logic [31:0] jt);
    cycle(r, st, br, j, rdy, bt, jt, 32'h2000_0000 + m_req_addr);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    stall = 0; branch_taken = 0; jump = 0; branch_target = 0; jump_target = 0;
    mem_if.MemReady = 0;
    mem_if.MemData  = 0;
    #1;
    check_eq("reset_address", address, RV);
    check_eq("reset_instr_valid", {31'b0, instr_valid}, 32'h0);

    // Reset, then sequential fetch with zero-wait memory
    dcyc(1, 0, 0, 0, 0, 0, 0);
    dcyc(1, 0, 0, 0, 0, 0, 0);
    dcyc(0, 0, 0, 0, 1, 0, 0);  // idle
    dcyc(0, 0, 0, 0, 1, 0, 0);  // issue 0
    check_eq("seq_instr_pc0", instr_pc, 32'h0);
    dcyc(0, 0, 0, 0, 1, 0, 0);  // deliver 0
    // Wait states on address 4
    for (int i = 0; i < 3; i++) dcyc(0, 0, 0, 0, 0, 0, 0);
    dcyc(0, 0, 0, 0, 1, 0, 0);
    check_eq("wait_instr", instruction, 32'h2000_0004);
    dcyc(0, 0, 0, 0, 1, 0, 0);  // deliver 4
    dcyc(0, 0, 0, 0, 1, 0, 0);  // issue 8
    // Stall for five cycles in deliver of 8
    for (int i = 0; i < 5; i++) dcyc(0, 1, 0, 0, 1, 0, 0);
    check_eq("stall_instr_pc", instr_pc, 32'h8);
    dcyc(0, 0, 0, 0, 1, 0, 0);  // stall drops: address 12
    // Branch while waiting on 12
    dcyc(0, 0, 0, 0, 0, 0, 0);
    dcyc(0, 0, 1, 0, 0, 32'h0000_0103, 0);
    dcyc(0, 0, 0, 0, 1, 0, 0);  // squashed data returns
    check_eq("redir_mem_addr", mem_if.MemAddr, 32'h100);
    dcyc(0, 0, 0, 0, 1, 0, 0);  // issue 0x100
    // Jump and branch together in deliver
    dcyc(0, 0, 1, 1, 1, 32'h80, 32'h40);
    check_eq("prio_pc", pc, 32'h40);
    // Wrap: redirect to the last word, then accept it
    dcyc(0, 0, 0, 1, 1, 0, 32'hFFFF_FFFC);
    dcyc(0, 0, 0, 0, 1, 0, 0);
    check_eq("wrap_address", address, 32'h0);
    dcyc(0, 0, 0, 0, 1, 0, 0);
    dcyc(0, 0, 0, 0, 0, 0, 0);
    dcyc(0, 0, 0, 0, 0, 0, 0);  // now waiting
    // Asynchronous reset mid-WAIT
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("amid_mem_req", {31'b0, mem_if.MemReq}, 32'h0);
    check_eq("amid_instr_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("amid_address", address, RV);
    @(posedge clk);
    #1;
    dcyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) dcyc(0, 0, 0, 0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 2) != 0),
            $urandom, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
